// File: rtl/lion_gate_driver_if.sv
// Command and gate-output bundle for the lion gate stimulus driver.
// The driver sits on the slave side; whoever issues bursts uses the master side.
interface lion_gate_driver_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_dir;
  logic [3:0] cmd_count;
  logic       clear_shadow;
  logic       g_one;
  logic       g_two;
  logic       busy;
  logic       done;
  logic [3:0] shadow_count;

  modport master (
    output cmd_valid, cmd_dir, cmd_count, clear_shadow,
    input  cmd_ready, g_one, g_two, busy, done, shadow_count
  );

  modport slave (
    input  cmd_valid, cmd_dir, cmd_count, clear_shadow,
    output cmd_ready, g_one, g_two, busy, done, shadow_count
  );
endinterface

// File: rtl/lion_gate_driver.sv
// Transmit end of the lion-cage light-gate protocol: plays N entry or exit
// traversals on g_one/g_two and keeps a shadow of the count a decoder must reach.
module lion_gate_driver #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 3,
  parameter int TW          = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  lion_gate_driver_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PH_A = 3'd1,
    ST_PH_B = 3'd2,
    ST_PH_C = 3'd3,
    ST_GAP  = 3'd4
  } state_t;

  localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES - 1);

  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic [3:0]    r_remaining;
  logic          r_dir;
  logic          r_null;
  logic          r_g_one;
  logic          r_g_two;
  logic          r_done;
  logic [3:0]    r_shadow;

  state_t        w_state;
  logic [TW-1:0] w_timer;
  logic [3:0]    w_remaining;
  logic          w_dir;
  logic          w_null;
  logic          w_g_one;
  logic          w_g_two;
  logic          w_done;
  logic          w_inc;
  logic          w_dec;
  logic [3:0]    w_shadow;
  logic          w_timer_zero;
  logic          w_accept;

  assign w_timer_zero = (r_timer == {TW{1'b0}});
  assign w_accept     = bus.cmd_valid && (r_state == ST_IDLE);

  // Next-state and next-output decode for the burst sequencer.
  always_comb begin
    w_state     = r_state;
    w_timer     = r_timer;
    w_remaining = r_remaining;
    w_dir       = r_dir;
    w_null      = r_null;
    w_g_one     = r_g_one;
    w_g_two     = r_g_two;
    w_done      = 1'b0;
    w_inc       = 1'b0;
    w_dec       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_dir = bus.cmd_dir;
          if (bus.cmd_count == 4'd0) begin
            // Empty burst: one silent GAP cycle stands in as the busy cycle.
            w_state     = ST_GAP;
            w_null      = 1'b1;
            w_timer     = {TW{1'b0}};
            w_remaining = 4'd0;
          end else begin
            w_state     = ST_PH_A;
            w_null      = 1'b0;
            w_timer     = HOLD_LOAD;
            w_remaining = bus.cmd_count - 4'd1;
            w_g_one     = bus.cmd_dir;
            w_g_two     = ~bus.cmd_dir;
            w_inc       = bus.cmd_dir;
          end
        end else begin
          w_state = ST_IDLE;
        end
      end

      ST_PH_A: begin
        if (w_timer_zero) begin
          w_state = ST_PH_B;
          w_timer = HOLD_LOAD;
          w_g_one = 1'b1;
          w_g_two = 1'b1;
        end else begin
          w_timer = r_timer - {{(TW-1){1'b0}}, 1'b1};
        end
      end

      ST_PH_B: begin
        if (w_timer_zero) begin
          w_state = ST_PH_C;
          w_timer = HOLD_LOAD;
          w_g_one = ~r_dir;
          w_g_two = r_dir;
        end else begin
          w_timer = r_timer - {{(TW-1){1'b0}}, 1'b1};
        end
      end

      ST_PH_C: begin
        if (w_timer_zero) begin
          w_g_one = 1'b0;
          w_g_two = 1'b0;
          w_dec   = ~r_dir;
          if (r_remaining != 4'd0) begin
            w_state     = ST_GAP;
            w_timer     = GAP_LOAD;
            w_remaining = r_remaining - 4'd1;
          end else begin
            w_state = ST_IDLE;
            w_done  = 1'b1;
          end
        end else begin
          w_timer = r_timer - {{(TW-1){1'b0}}, 1'b1};
        end
      end

      ST_GAP: begin
        if (w_timer_zero) begin
          if (r_null) begin
            w_state = ST_IDLE;
            w_null  = 1'b0;
            w_done  = 1'b1;
          end else begin
            w_state = ST_PH_A;
            w_timer = HOLD_LOAD;
            w_g_one = r_dir;
            w_g_two = ~r_dir;
            w_inc   = r_dir;
          end
        end else begin
          w_timer = r_timer - {{(TW-1){1'b0}}, 1'b1};
        end
      end

      default: begin
        w_state     = ST_IDLE;
        w_timer     = {TW{1'b0}};
        w_remaining = 4'd0;
        w_null      = 1'b0;
        w_g_one     = 1'b0;
        w_g_two     = 1'b0;
      end
    endcase
  end

  // Shadow count: clear wins over an update landing on the same edge.
  always_comb begin
    w_shadow = r_shadow;
    if (bus.clear_shadow) begin
      w_shadow = 4'd0;
    end else if (w_inc) begin
      w_shadow = r_shadow + 4'd1;
    end else if (w_dec) begin
      w_shadow = r_shadow - 4'd1;
    end else begin
      w_shadow = r_shadow;
    end
  end

  // State and registered outputs; reset drops the gates immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_timer     <= {TW{1'b0}};
      r_remaining <= 4'd0;
      r_dir       <= 1'b0;
      r_null      <= 1'b0;
      r_g_one     <= 1'b0;
      r_g_two     <= 1'b0;
      r_done      <= 1'b0;
      r_shadow    <= 4'd0;
    end else begin
      r_state     <= w_state;
      r_timer     <= w_timer;
      r_remaining <= w_remaining;
      r_dir       <= w_dir;
      r_null      <= w_null;
      r_g_one     <= w_g_one;
      r_g_two     <= w_g_two;
      r_done      <= w_done;
      r_shadow    <= w_shadow;
    end
  end

  assign bus.cmd_ready    = (r_state == ST_IDLE);
  assign bus.busy         = (r_state != ST_IDLE);
  assign bus.g_one        = r_g_one;
  assign bus.g_two        = r_g_two;
  assign bus.done         = r_done;
  assign bus.shadow_count = r_shadow;

endmodule

// File: tb/tb_lion_gate_driver.sv
// Scoreboarded bench for lion_gate_driver: stimulus pushes expected burst results,
// a negedge monitor decodes the gates like the lion counter and checks each done.
module tb_lion_gate_driver;
  localparam int HOLD = 4;
  localparam int GAP  = 3;

  typedef struct {
    logic [3:0] shadow;
    logic [3:0] lion;
    int         latency;
    int         rises;
    int         falls;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  lion_gate_driver_if bus();

  lion_gate_driver #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .TW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t       sb_q[$];
  int         n_checks    = 0;
  int         n_fail      = 0;
  int         cyc         = 0;
  int         exp_accepts = 0;
  int         mon_accepts = 0;
  int         bad_jumps   = 0;
  logic [3:0] exp_shadow  = 4'd0;
  logic [3:0] exp_lion    = 4'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: lion-counter style gate decode plus scoreboard pop on done
  initial begin
    int         acc_cyc;
    int         rises;
    int         falls;
    logic [3:0] lion;
    logic       p1;
    logic       p2;
    exp_t       e;
    acc_cyc = 0; rises = 0; falls = 0; lion = 4'd0; p1 = 1'b0; p2 = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        lion = 4'd0; p1 = 1'b0; p2 = 1'b0;
      end else begin
        if (!p1 && bus.g_one && !p2 && !bus.g_two) begin
          lion = lion + 4'd1; rises++;
        end
        if (p1 && !bus.g_one && !p2 && !bus.g_two) begin
          lion = lion - 4'd1; falls++;
        end
        if ((p1 == p2) && (bus.g_one == bus.g_two) && (p1 != bus.g_one)) bad_jumps++;
        p1 = bus.g_one;
        p2 = bus.g_two;
        if (bus.done) begin
          if (sb_q.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            e = sb_q.pop_front();
            check("done_shadow",  int'(bus.shadow_count), int'(e.shadow));
            check("done_lion",    int'(lion),             int'(e.lion));
            check("done_latency", cyc - acc_cyc,          e.latency);
            check("done_rises",   rises,                  e.rises);
            check("done_falls",   falls,                  e.falls);
          end
        end
        if (bus.cmd_valid && bus.cmd_ready) begin
          mon_accepts++;
          acc_cyc = cyc + 1;
          rises = 0;
          falls = 0;
        end
      end
    end
  end

  // Issue one burst; returns just after the accepting edge (or after done when hold=1)
  task automatic issue(input logic dir, input int n, input logic clr, input logic hold);
    exp_t e;
    bit   got;
    @(posedge clk);
    #1;
    bus.cmd_valid    = 1'b1;
    bus.cmd_dir      = dir;
    bus.cmd_count    = 4'(n);
    bus.clear_shadow = clr;
    got = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      check("ready_timeout", 0, 1);
      bus.cmd_valid    = 1'b0;
      bus.clear_shadow = 1'b0;
      return;
    end
    if (clr) exp_shadow = dir ? 4'(n - 1) : 4'(0 - n);
    else     exp_shadow = dir ? exp_shadow + 4'(n) : exp_shadow - 4'(n);
    exp_lion  = dir ? exp_lion + 4'(n) : exp_lion - 4'(n);
    e.shadow  = exp_shadow;
    e.lion    = exp_lion;
    e.latency = (n == 0) ? 1 : n * 3 * HOLD + (n - 1) * GAP;
    e.rises   = dir ? n : 0;
    e.falls   = dir ? 0 : n;
    sb_q.push_back(e);
    exp_accepts++;
    @(posedge clk);
    #1;
    bus.clear_shadow = 1'b0;
    if (hold) begin
      got = 1'b0;
      for (int i = 0; i < 1000; i++) begin
        if (bus.done) begin
          got = 1'b1;
          break;
        end
        @(posedge clk);
        #1;
      end
      if (!got) check("hold_done_timeout", 0, 1);
    end
    bus.cmd_valid = 1'b0;
  endtask

  initial begin
    logic [3:0] want;
    bus.cmd_valid    = 1'b0;
    bus.cmd_dir      = 1'b0;
    bus.cmd_count    = 4'd0;
    bus.clear_shadow = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", int'({bus.g_one, bus.g_two, bus.done, bus.busy, bus.cmd_ready}), 1);
    check("rst_shadow", int'(bus.shadow_count), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", int'({bus.cmd_ready, bus.busy}), 2);

    // Single entry: cycle-by-cycle waveform after accept
    issue(1'b1, 1, 1'b0, 1'b0);
    for (int i = 1; i <= 13; i++) begin
      @(negedge clk);
      want = (i <= 4) ? 4'b1010 : (i <= 8) ? 4'b1110 : (i <= 12) ? 4'b0110 : 4'b0001;
      check($sformatf("entry1_c%0d_g1g2busydone", i),
            int'({bus.g_one, bus.g_two, bus.busy, bus.done}), int'(want));
      check($sformatf("entry1_c%0d_shadow", i), int'(bus.shadow_count), 1);
    end

    issue(1'b0, 2, 1'b0, 1'b0);   // exit x2: 1 -> 15
    issue(1'b1, 6, 1'b0, 1'b0);   // 15 -> 5
    issue(1'b1, 15, 1'b0, 1'b0);  // 5 -> 4 through the wrap

    // Empty burst: one busy cycle, then done, gates untouched
    issue(1'b1, 0, 1'b0, 1'b0);
    @(negedge clk);
    check("zero_c1_g1g2busydone", int'({bus.g_one, bus.g_two, bus.busy, bus.done}), 2);
    @(negedge clk);
    check("zero_c2_g1g2busydone", int'({bus.g_one, bus.g_two, bus.busy, bus.done}), 1);
    check("zero_shadow", int'(bus.shadow_count), 4);

    // cmd_valid held through a burst: only one accept
    issue(1'b1, 2, 1'b0, 1'b1);

    // Reset during PH_B of an entry burst
    issue(1'b1, 3, 1'b0, 1'b0);
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_gates", int'({bus.g_one, bus.g_two}), 0);
    check("midrst_shadow", int'(bus.shadow_count), 0);
    check("midrst_ready_busy_done", int'({bus.cmd_ready, bus.busy, bus.done}), 4);
    sb_q.delete();
    exp_shadow = 4'd0;
    exp_lion   = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Closed loop against the decoder model
    issue(1'b1, 3, 1'b0, 1'b0);
    issue(1'b0, 1, 1'b0, 1'b0);
    for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(negedge clk);
    check("loop_shadow", int'(bus.shadow_count), 2);

    // Clear on the same edge as an entry increment
    issue(1'b1, 1, 1'b1, 1'b0);
    @(negedge clk);
    check("clear_vs_inc_shadow", int'(bus.shadow_count), 0);

    for (int i = 0; i < 2000 && sb_q.size() != 0; i++) @(negedge clk);
    check("sb_drained", sb_q.size(), 0);
    check("accept_count", mon_accepts, exp_accepts);
    check("no_00_11_jumps", bad_jumps, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
